// File: rtl/pim_inst_sequencer.sv
// pim_inst_sequencer: decodes PIM/normal instruction words into PRE/WORK macro control sequences.
// Optional illegal-instruction trap enabled by defining PIM_ILLEGAL_TRAP_EN.
module pim_inst_sequencer #(
  parameter int INST_W       = 32,
  parameter int ROW_AW       = 8,
  parameter int WORK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_valid_i,
  output logic              inst_ready_o,
  input  logic [INST_W-1:0] inst_i,
  input  logic              mem_done_i,
  output logic              cd_o,
  output logic              nwr_o,
  output logic              nrd_o,
  output logic [3:0]        mode_o,
  output logic [3:0]        opcode_o,
  output logic [1:0]        width_o,
  output logic [ROW_AW-1:0] row_a_o,
  output logic [ROW_AW-1:0] row_b_o,
  output logic [5:0]        imm_o,
  output logic              busy_o,
  output logic              timeout_o,
  output logic              err_o
);
  typedef enum logic [1:0] {IDLE, PRE, WORK} state_e;
  localparam logic [1:0] CLS_NOP = 2'b00, CLS_NRD = 2'b01, CLS_PIM = 2'b11;
  localparam logic [3:0] MODE_NR = 4'd0, MODE_NW = 4'd1, MODE_PW = 4'd3, MODE_NP = 4'd7, MODE_PP = 4'd8;
  localparam int CNT_W = $clog2(WORK_TIMEOUT + 1);
  state_e           r_state;
  logic [1:0]       r_cls, r_am;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ready, r_cd, r_nwr, r_nrd, r_busy, r_timeout;
  logic [3:0]       r_mode, r_op;
  logic [1:0]       r_width;
  logic [ROW_AW-1:0] r_row_a, r_row_b;
  logic [5:0]       r_imm;
  logic [1:0]       w_cls, w_am;
  logic [3:0]       w_op;
  logic             w_hs, w_trap, w_end;
  assign w_cls = inst_i[31:30];
  assign w_op  = inst_i[29:26];
  assign w_am  = inst_i[25:24];
  assign w_hs  = inst_valid_i & r_ready;
  assign w_end = mem_done_i | (r_cnt == CNT_W'(WORK_TIMEOUT - 1));
`ifdef PIM_ILLEGAL_TRAP_EN
  localparam logic [3:0] ALU_ADI = 4'b1001, ALU_SADI = 4'b1011, ALU_M_ADI = 4'b1101;
  logic r_err;
  // immediate forms only make sense with the RSS addressing mode
  assign w_trap = (w_cls == CLS_PIM) &&
                  ((w_op == 4'b0000) || ((w_op == ALU_ADI || w_op == ALU_SADI || w_op == ALU_M_ADI) && w_am != 2'b00));
  assign err_o  = r_err;
`else
  assign w_trap = 1'b0;
  assign err_o  = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cls     <= CLS_NOP;
      r_am      <= 2'b00;
      r_cnt     <= '0;
      r_ready   <= 1'b1;
      r_cd      <= 1'b0;
      r_nwr     <= 1'b1;
      r_nrd     <= 1'b1;
      r_mode    <= MODE_NP;
      r_op      <= '0;
      r_width   <= '0;
      r_row_a   <= '0;
      r_row_b   <= '0;
      r_imm     <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
`ifdef PIM_ILLEGAL_TRAP_EN
      r_err     <= 1'b0;
`endif
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_hs && w_trap) begin
`ifdef PIM_ILLEGAL_TRAP_EN
            r_err <= 1'b1;
`endif
          end else if (w_hs && w_cls != CLS_NOP) begin
            r_state <= PRE;
            r_cls   <= w_cls;
            r_am    <= w_am;
            r_op    <= w_op;
            r_width <= inst_i[23:22];
            r_row_a <= inst_i[21:14];
            r_row_b <= inst_i[13:6];
            r_imm   <= inst_i[5:0];
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_cd    <= w_cls == CLS_PIM;
            r_mode  <= w_cls == CLS_PIM ? MODE_PP + {2'b00, w_am} : MODE_NP;
          end
        end
        PRE: begin
          r_state <= WORK;
          r_cnt   <= '0;
          r_nwr   <= r_cls == CLS_NRD;
          r_nrd   <= r_cls != CLS_NRD;
          r_mode  <= r_cls == CLS_PIM ? MODE_PW + {2'b00, r_am} : r_cls == CLS_NRD ? MODE_NR : MODE_NW;
        end
        WORK: begin
          if (w_end) begin
            r_state   <= IDLE;
            r_timeout <= ~mem_done_i;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_cd      <= 1'b0;
            r_nwr     <= 1'b1;
            r_nrd     <= 1'b1;
            r_mode    <= MODE_NP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign inst_ready_o = r_ready;
  assign cd_o         = r_cd;
  assign nwr_o        = r_nwr;
  assign nrd_o        = r_nrd;
  assign mode_o       = r_mode;
  assign opcode_o     = r_op;
  assign width_o      = r_width;
  assign row_a_o      = r_row_a;
  assign row_b_o      = r_row_b;
  assign imm_o        = r_imm;
  assign busy_o       = r_busy;
  assign timeout_o    = r_timeout;
endmodule

// File: tb/tb_pim_inst_sequencer.sv
// tb_pim_inst_sequencer: table-driven and scoreboard checks of the instruction sequencer.
module tb_pim_inst_sequencer;
  logic        clk = 1'b0, rst = 1'b1, inst_valid_i = 1'b0, mem_done_i = 1'b0;
  logic [31:0] inst_i = '0;
  logic        inst_ready_o, cd_o, nwr_o, nrd_o, busy_o, timeout_o, err_o;
  logic [3:0]  mode_o, opcode_o;
  logic [1:0]  width_o;
  logic [7:0]  row_a_o, row_b_o;
  logic [5:0]  imm_o;
  pim_inst_sequencer dut (
    .clk(clk), .rst(rst), .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o),
    .inst_i(inst_i), .mem_done_i(mem_done_i), .cd_o(cd_o), .nwr_o(nwr_o), .nrd_o(nrd_o),
    .mode_o(mode_o), .opcode_o(opcode_o), .width_o(width_o), .row_a_o(row_a_o),
    .row_b_o(row_b_o), .imm_o(imm_o), .busy_o(busy_o), .timeout_o(timeout_o), .err_o(err_o)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0;
  int hs[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (inst_valid_i && inst_ready_o) hs.push_back(cyc);
  end
  // {cd,nwr,nrd,mode,busy,ready,timeout}
  typedef logic [9:0] snap_t;
  localparam snap_t IDLE_S = {3'b011, 4'd7, 3'b010};
  snap_t sb[$];
  typedef struct {
    logic [31:0] inst;
    logic [3:0]  pm;
    logic [2:0]  pc;
    logic [3:0]  wm;
    logic [2:0]  wc;
    int          done_at;
    logic        tmo;
    logic        trap;
  } vec_t;
  vec_t vecs[11];
  task automatic chk(input string nm);
    snap_t e, a;
    checks++;
    a = {cd_o, nwr_o, nrd_o, mode_o, busy_o, inst_ready_o, timeout_o};
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got %h", nm, a);
    end else begin
      e = sb.pop_front();
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", nm, a, e);
      end
    end
  endtask
  task automatic cmp(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_vec(input vec_t v);
    int n = 0;
    while (!inst_ready_o && n < 50) begin step(); n++; end
    cmp("ready_wait", inst_ready_o, 1);
    inst_i = v.inst;
    inst_valid_i = 1'b1;
    step();
    inst_valid_i = 1'b0;
    if (v.trap) begin
      sb.push_back(IDLE_S);
      chk("trap_idle");
      cmp("trap_err", err_o, 1);
      return;
    end
    sb.push_back({v.pc, v.pm, 3'b100});
    chk("pre");
    cmp("opcode", opcode_o, v.inst[29:26]);
    cmp("width", width_o, v.inst[23:22]);
    cmp("row_a", row_a_o, v.inst[21:14]);
    cmp("row_b", row_b_o, v.inst[13:6]);
    cmp("imm", imm_o, v.inst[5:0]);
    step();
    for (int c = 1; c <= 15; c++) begin
      sb.push_back({v.wc, v.wm, 3'b100});
      chk("work");
      mem_done_i = (c == v.done_at);
      step();
      mem_done_i = 1'b0;
      if (c == v.done_at) break;
    end
    sb.push_back({3'b011, 4'd7, 2'b01, v.tmo});
    chk("end");
    if (v.tmo) begin
      step();
      cmp("tmo_clear", timeout_o, 0);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    int base;
    logic trap_on;
`ifdef PIM_ILLEGAL_TRAP_EN
    trap_on = 1'b1;
`else
    trap_on = 1'b0;
`endif
    vecs[0]  = '{{2'b01, 4'h0, 2'b00, 2'b00, 8'h3C, 8'h00, 6'h00}, 4'd7, 3'b011, 4'd0, 3'b010, 2, 1'b0, 1'b0};
    vecs[1]  = '{{2'b10, 4'h3, 2'b01, 2'b10, 8'hA5, 8'h5A, 6'h2A}, 4'd7, 3'b011, 4'd1, 3'b001, 1, 1'b0, 1'b0};
    vecs[2]  = '{{2'b11, 4'h8, 2'b10, 2'b01, 8'h12, 8'h34, 6'h15}, 4'd10, 3'b111, 4'd5, 3'b101, 3, 1'b0, 1'b0};
    vecs[3]  = '{{2'b11, 4'hA, 2'b00, 2'b11, 8'hFF, 8'h01, 6'h3F}, 4'd8, 3'b111, 4'd3, 3'b101, 1, 1'b0, 1'b0};
    vecs[4]  = '{{2'b11, 4'h8, 2'b01, 2'b00, 8'h80, 8'h7F, 6'h01}, 4'd9, 3'b111, 4'd4, 3'b101, 4, 1'b0, 1'b0};
    vecs[5]  = '{{2'b11, 4'h8, 2'b11, 2'b10, 8'h0F, 8'hF0, 6'h20}, 4'd11, 3'b111, 4'd6, 3'b101, 1, 1'b0, 1'b0};
    vecs[6]  = '{{2'b01, 4'h0, 2'b00, 2'b00, 8'h11, 8'h22, 6'h00}, 4'd7, 3'b011, 4'd0, 3'b010, 0, 1'b1, 1'b0};
    vecs[7]  = '{{2'b11, 4'h8, 2'b00, 2'b00, 8'h44, 8'h55, 6'h0A}, 4'd8, 3'b111, 4'd3, 3'b101, 15, 1'b0, 1'b0};
    vecs[8]  = '{{2'b11, 4'h0, 2'b00, 2'b00, 8'h66, 8'h77, 6'h0B}, 4'd8, 3'b111, 4'd3, 3'b101, 1, 1'b0, trap_on};
    vecs[9]  = '{{2'b11, 4'h9, 2'b11, 2'b00, 8'h01, 8'h02, 6'h03}, 4'd11, 3'b111, 4'd6, 3'b101, 2, 1'b0, trap_on};
    vecs[10] = '{{2'b11, 4'h9, 2'b00, 2'b00, 8'h09, 8'h0A, 6'h0C}, 4'd8, 3'b111, 4'd3, 3'b101, 1, 1'b0, 1'b0};
    repeat (3) @(posedge clk);
    #1;
    sb.push_back(IDLE_S);
    chk("reset");
    cmp("reset_opcode", opcode_o, 0);
    cmp("reset_rows", {row_a_o, row_b_o, imm_o, width_o}, 0);
    cmp("reset_err", err_o, 0);
    rst = 1'b0;
    step();
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);
    // NOP is swallowed: stays idle, fields keep the previous word
    inst_i = 32'h3FFF_FFFF;
    inst_valid_i = 1'b1;
    step();
    inst_valid_i = 1'b0;
    sb.push_back(IDLE_S);
    chk("nop_idle");
    cmp("nop_fields", {opcode_o, row_a_o}, {vecs[7].inst[29:26], vecs[7].inst[21:14]});
    // back-to-back with valid held and done held high
    base = hs.size();
    mem_done_i = 1'b1;
    inst_i = vecs[2].inst;
    inst_valid_i = 1'b1;
    n = 0;
    while (hs.size() < base + 1 && n < 20) begin step(); n++; end
    inst_i = vecs[1].inst;
    n = 0;
    while (hs.size() < base + 2 && n < 20) begin step(); n++; end
    inst_valid_i = 1'b0;
    cmp("b2b_count", hs.size(), base + 2);
    if (hs.size() >= base + 2) cmp("b2b_period", hs[base+1] - hs[base], 3);
    sb.push_back({3'b011, 4'd7, 3'b100});
    chk("b2b_pre2");
    step();
    step();
    mem_done_i = 1'b0;
    sb.push_back(IDLE_S);
    chk("b2b_idle");
    // reset in the middle of WORK
    inst_i = vecs[1].inst;
    inst_valid_i = 1'b1;
    step();
    inst_valid_i = 1'b0;
    step();
    sb.push_back({3'b001, 4'd1, 3'b100});
    chk("rst_work");
    rst = 1'b1;
    #1;
    sb.push_back(IDLE_S);
    chk("rst_abort");
    cmp("rst_fields", {opcode_o, row_a_o, row_b_o}, 0);
    step();
    rst = 1'b0;
    step();
    run_vec(vecs[0]);
    for (int i = 8; i < 11; i++) run_vec(vecs[i]);
    cmp("final_err", err_o, trap_on);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
